// File: rtl/coin_acceptor.sv
// Coin-chute front end: synchronizes, debounces and arbitrates two raw sensors into single-cycle N/D/reject pulses.
// Optional per-outcome event counters are built when COIN_ACCEPTOR_COUNT_EN is defined.
module coin_acceptor #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int STUCK_CYCLES    = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        n_raw,
  input  logic        d_raw,
  input  logic        enable,
  output logic        N,
  output logic        D,
  output logic        reject,
  output logic        busy,
  output logic        fault
`ifdef COIN_ACCEPTOR_COUNT_EN
  ,
  output logic [15:0] n_count,
  output logic [15:0] d_count,
  output logic [15:0] rej_count
`endif
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int SW = $clog2(STUCK_CYCLES);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SW-1:0] ST_LAST = SW'(STUCK_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    QUAL,
    EMIT,
    RELEASE,
    FAULT
  } state_t;

  state_t        state, state_nx;
  logic [1:0]    n_sync, d_sync;
  logic          n_s, d_s;
  logic          coin_is_dime, dime_nx;
  logic [DW-1:0] deb_cnt, deb_nx;
  logic [SW-1:0] stuck_cnt, stuck_nx;
  logic          rej_q, rej_nx;
  logic          latched_hi, other_hi, any_hi;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      n_sync <= '0;
      d_sync <= '0;
    end else begin
      n_sync <= {n_sync[0], n_raw};
      d_sync <= {d_sync[0], d_raw};
    end
  end

  assign n_s = n_sync[1];
  assign d_s = d_sync[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      coin_is_dime <= 1'b0;
      deb_cnt      <= '0;
      stuck_cnt    <= '0;
      rej_q        <= 1'b0;
    end else begin
      state        <= state_nx;
      coin_is_dime <= dime_nx;
      deb_cnt      <= deb_nx;
      stuck_cnt    <= stuck_nx;
      rej_q        <= rej_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    dime_nx    = coin_is_dime;
    deb_nx     = deb_cnt;
    stuck_nx   = stuck_cnt;
    rej_nx     = 1'b0;
    latched_hi = coin_is_dime ? d_s : n_s;
    other_hi   = coin_is_dime ? n_s : d_s;
    any_hi     = n_s | d_s;

    case (state)
      IDLE: begin
        if (any_hi) begin
          if (enable && (n_s ^ d_s)) begin
            dime_nx  = d_s;
            deb_nx   = '0;
            state_nx = QUAL;
          end else begin
            // Disabled or simultaneous coins are refused and must clear the chute.
            rej_nx   = 1'b1;
            deb_nx   = '0;
            stuck_nx = '0;
            state_nx = RELEASE;
          end
        end
      end

      QUAL: begin
        if (other_hi) begin
          rej_nx   = 1'b1;
          deb_nx   = '0;
          stuck_nx = '0;
          state_nx = RELEASE;
        end else if (!latched_hi) begin
          state_nx = IDLE;
        end else if (deb_cnt == DB_LAST) begin
          state_nx = EMIT;
        end else begin
          deb_nx = deb_cnt + DW'(1);
        end
      end

      EMIT: begin
        deb_nx   = '0;
        stuck_nx = '0;
        state_nx = RELEASE;
      end

      RELEASE: begin
        // The release and stuck counters are mutually clearing: one counts lows, the other highs.
        if (any_hi) begin
          deb_nx = '0;
          if (stuck_cnt == ST_LAST) begin
            state_nx = FAULT;
          end else begin
            stuck_nx = stuck_cnt + SW'(1);
          end
        end else begin
          stuck_nx = '0;
          if (deb_cnt == DB_LAST) begin
            state_nx = IDLE;
          end else begin
            deb_nx = deb_cnt + DW'(1);
          end
        end
      end

      FAULT: begin
        state_nx = FAULT;
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign N      = (state == EMIT) && !coin_is_dime;
  assign D      = (state == EMIT) && coin_is_dime;
  assign reject = rej_q;
  assign busy   = (state != IDLE);
  assign fault  = (state == FAULT);

`ifdef COIN_ACCEPTOR_COUNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      n_count   <= '0;
      d_count   <= '0;
      rej_count <= '0;
    end else begin
      if (N && (n_count != '1)) n_count <= n_count + 16'd1;
      if (D && (d_count != '1)) d_count <= d_count + 16'd1;
      if (reject && (rej_count != '1)) rej_count <= rej_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_coin_acceptor.sv
// Bench for coin_acceptor: directed vector table, multi-cycle corner sequences and randomized coins
// checked against an event-level timing model.
module tb_coin_acceptor;

  localparam int DB = 4;
  localparam int ST = 64;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic n_raw = 1'b0;
  logic d_raw = 1'b0;
  logic enable = 1'b0;
  logic N, D, reject, busy, fault;
`ifdef COIN_ACCEPTOR_COUNT_EN
  logic [15:0] n_count, d_count, rej_count;
`endif

  coin_acceptor #(.DEBOUNCE_CYCLES(DB), .STUCK_CYCLES(ST)) dut (
    .clk(clk),
    .reset(reset),
    .n_raw(n_raw),
    .d_raw(d_raw),
    .enable(enable),
    .N(N),
    .D(D),
    .reject(reject),
    .busy(busy),
    .fault(fault)
`ifdef COIN_ACCEPTOR_COUNT_EN
    ,
    .n_count(n_count),
    .d_count(d_count),
    .rej_count(rej_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int kind;   // 1 = N, 2 = D, 3 = reject
  } pulse_t;

  typedef struct {
    int kind;   // 1 = nickel chute, 2 = dime chute, 3 = both chutes
    bit en;
    int hold;
    int gap;
    int exp_kind;
    int exp_at;
    int exp_free;
  } vec_t;

  int     cyc = 0;
  int     errors = 0;
  int     checks = 0;
  int     busy_fall = -1;
  logic   prev_busy = 1'b0;
  pulse_t obs[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset) begin
      if (N) obs.push_back('{cyc, 1});
      if (D) obs.push_back('{cyc, 2});
      if (reject) obs.push_back('{cyc, 3});
      checks++;
      if ((N && D) || (reject && (N || D))) begin
        errors++;
        $display("FAIL exclusive @%0d: N=%0b D=%0b reject=%0b, need at most one high", cyc, N, D, reject);
      end
      if (prev_busy && !busy) busy_fall = cyc;
    end
    prev_busy = busy;
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Offsets are counted from the cycle the raw sensor is first driven:
  // 2 synchronizer edges, 1 IDLE sample, DB qualifying samples, then the pulse cycle.
  task automatic model(input int kind, input bit en, input int hold,
                       output int ek, output int at, output int fr);
    int rel_edge;
    int first_low;
    first_low = hold + 2;
    if (!en || kind == 3) begin
      ek = 3;
      at = 3;
      rel_edge = 2;
      fr = 1 + ((rel_edge + 1 > first_low) ? rel_edge + 1 : first_low) + DB - 1;
    end else if (hold >= DB + 1) begin
      ek = kind;
      at = DB + 3;
      rel_edge = DB + 3;
      fr = 1 + ((rel_edge + 1 > first_low) ? rel_edge + 1 : first_low) + DB - 1;
    end else begin
      ek = 0;
      at = 0;
      fr = hold + 3;
    end
  endtask

  task automatic run_txn(input int id, input int kind, input bit en, input int hold, input int gap,
                         input int ek, input int at, input int fr);
    int c0;
    obs.delete();
    busy_fall = -1;
    c0 = cyc;
    enable = en;
    n_raw = (kind == 1 || kind == 3);
    d_raw = (kind == 2 || kind == 3);
    repeat (hold) step();
    n_raw = 1'b0;
    d_raw = 1'b0;
    repeat (gap) step();
    chk($sformatf("txn%0d pulse_count", id), obs.size(), (ek == 0) ? 0 : 1);
    if (ek != 0 && obs.size() >= 1) begin
      chk($sformatf("txn%0d pulse_kind", id), obs[0].kind, ek);
      chk($sformatf("txn%0d pulse_cycle", id), obs[0].cyc - c0, at);
    end
    chk($sformatf("txn%0d busy_release", id), busy_fall - c0, fr);
  endtask

  vec_t vecs[8];

  initial begin
    int c0;
    int ek, at, fr, kind, hold, gap;
    bit en;

    vecs[0] = '{1, 1'b1, 20, 10, 1, 7, 26};  // clean long nickel
    vecs[1] = '{2, 1'b1,  2,  8, 0, 0,  5};  // short dime glitch
    vecs[2] = '{1, 1'b0, 10,  8, 3, 3, 16};  // nickel while disabled
    vecs[3] = '{2, 1'b1,  8,  8, 2, 7, 14};  // clean dime
    vecs[4] = '{3, 1'b1,  5,  8, 3, 3, 11};  // both chutes at once
    vecs[5] = '{1, 1'b1,  4,  8, 0, 0,  7};  // one sample short of qualifying
    vecs[6] = '{1, 1'b1,  5,  8, 1, 7, 12};  // minimum qualifying hold
    vecs[7] = '{2, 1'b1,  1,  8, 0, 0,  4};  // single-cycle blip

    repeat (3) step();
    chk("reset_outputs", {27'd0, N, D, reject, busy, fault}, 0);
    reset = 1'b0;
    repeat (2) step();
    chk("idle_outputs", {27'd0, N, D, reject, busy, fault}, 0);

    foreach (vecs[i])
      run_txn(i, vecs[i].kind, vecs[i].en, vecs[i].hold, vecs[i].gap,
              vecs[i].exp_kind, vecs[i].exp_at, vecs[i].exp_free);

    // Dime qualifying, then the nickel chute joins mid-qualification.
    obs.delete();
    busy_fall = -1;
    c0 = cyc;
    enable = 1'b1;
    d_raw = 1'b1;
    repeat (3) step();
    n_raw = 1'b1;
    repeat (10) step();
    n_raw = 1'b0;
    d_raw = 1'b0;
    repeat (10) step();
    chk("stagger pulse_count", obs.size(), 1);
    if (obs.size() >= 1) begin
      chk("stagger pulse_kind", obs[0].kind, 3);
      chk("stagger pulse_cycle", obs[0].cyc - c0, 6);
    end
    chk("stagger busy_release", busy_fall - c0, 19);

    for (int t = 0; t < 30; t++) begin
      kind = $urandom_range(3, 1);
      en   = ($urandom_range(3, 0) != 0);
      hold = $urandom_range(12, 1);
      gap  = $urandom_range(12, 8);
      model(kind, en, hold, ek, at, fr);
      run_txn(100 + t, kind, en, hold, gap, ek, at, fr);
    end

    // Stuck nickel sensor.
    obs.delete();
    c0 = cyc;
    enable = 1'b1;
    n_raw = 1'b1;
    repeat (71) step();
    chk("stuck fault_before", fault, 0);
    step();
    chk("stuck fault_raised", fault, 1);
    chk("stuck busy", busy, 1);
    repeat (28) step();
    n_raw = 1'b0;
    repeat (10) step();
    chk("stuck pulse_count", obs.size(), 1);
    if (obs.size() >= 1) begin
      chk("stuck pulse_kind", obs[0].kind, 1);
      chk("stuck pulse_cycle", obs[0].cyc - c0, 7);
    end
    obs.delete();
    n_raw = 1'b1;
    repeat (10) step();
    n_raw = 1'b0;
    repeat (10) step();
    chk("fault coin_ignored", obs.size(), 0);
    chk("fault sticky", fault, 1);
    reset = 1'b1;
    #1;
    chk("fault cleared", fault, 0);
    step();
    reset = 1'b0;
    repeat (2) step();

    // Reset while a dime is part-way through qualification.
    obs.delete();
    enable = 1'b1;
    d_raw = 1'b1;
    repeat (4) step();
    chk("midqual busy", busy, 1);
    #1 reset = 1'b1;
    #1;
    chk("midqual reset_outputs", {27'd0, N, D, reject, busy, fault}, 0);
    d_raw = 1'b0;
    repeat (2) step();
    reset = 1'b0;
    repeat (12) step();
    chk("midqual no_pulse", obs.size(), 0);

`ifdef COIN_ACCEPTOR_COUNT_EN
    for (int k = 0; k < 3; k++) run_txn(200 + k, 1, 1'b1, 6, 10, 1, 7, 12);
    run_txn(203, 1, 1'b0, 3, 10, 3, 3, 9);
    chk("n_count", n_count, 3);
    chk("d_count", d_count, 0);
    chk("rej_count", rej_count, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
